// File: rtl/sad_row_accumulator.sv
// sad_row_accumulator
// Sums ROWS_PER_CAND row partial SADs from the PE array into one block SAD per
// candidate and hands each result to the minimum-SAD tracker. A search covers
// NUM_CANDIDATES candidates. Results for candidates whose bit is clear in the
// mask latched at start still update out_SAD/out_cand_idx, but without a valid
// pulse.
//
// Ports:
//   in_clk               clock, rising edge
//   in_rst               asynchronous active-high reset
//   in_start             search start pulse, honoured only when idle
//   in_cand_mask         per-candidate enable, latched on an accepted start
//   in_partial_valid     in_partial_sum qualifier
//   in_partial_sum       unsigned row partial SAD
//   out_SAD              saturated SAD of the last finished candidate
//   out_SAD_valid_masked one-cycle pulse for an unmasked finished candidate
//   out_cand_idx         candidate index belonging to out_SAD
//   out_busy             search in progress
//   out_search_done      one-cycle pulse after the last candidate
module sad_row_accumulator #(
  parameter int MAX_DATA_WIDTH = 16,
  parameter int PARTIAL_WIDTH  = 12,
  parameter int ROWS_PER_CAND  = 16,
  parameter int NUM_CANDIDATES = 16,
  parameter int CAND_IDX_WIDTH = 5
) (
  input  logic                      in_clk,
  input  logic                      in_rst,
  input  logic                      in_start,
  input  logic [NUM_CANDIDATES-1:0] in_cand_mask,
  input  logic                      in_partial_valid,
  input  logic [PARTIAL_WIDTH-1:0]  in_partial_sum,
  output logic [MAX_DATA_WIDTH-1:0] out_SAD,
  output logic                      out_SAD_valid_masked,
  output logic [CAND_IDX_WIDTH-1:0] out_cand_idx,
  output logic                      out_busy,
  output logic                      out_search_done
);

  localparam int SUM_W = MAX_DATA_WIDTH + 1;
  localparam int ROW_W = (ROWS_PER_CAND > 1) ? $clog2(ROWS_PER_CAND) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                    r_state;
  logic [MAX_DATA_WIDTH-1:0] r_acc;
  logic [ROW_W-1:0]          r_row;
  logic [CAND_IDX_WIDTH-1:0] r_cand;
  logic [NUM_CANDIDATES-1:0] r_mask;

  logic [SUM_W-1:0]          w_sum;
  logic [MAX_DATA_WIDTH-1:0] w_acc_next;
  logic [NUM_CANDIDATES-1:0] w_mask_shift;
  logic                      w_mask_bit;
  logic                      w_last_row;
  logic                      w_last_cand;

  // Saturating accumulate: the extra sum bit flags overflow. Once the
  // accumulator is all-ones any further partial keeps it there.
  always_comb begin
    w_sum = {1'b0, r_acc} + SUM_W'(in_partial_sum);
    if (w_sum[MAX_DATA_WIDTH]) begin
      w_acc_next = {MAX_DATA_WIDTH{1'b1}};
    end else begin
      w_acc_next = w_sum[MAX_DATA_WIDTH-1:0];
    end
  end

  // Mask lookup and end-of-row / end-of-search detection.
  always_comb begin
    w_mask_shift = r_mask >> r_cand;
    w_mask_bit   = w_mask_shift[0];
    w_last_row   = (r_row == ROW_W'(ROWS_PER_CAND - 1));
    w_last_cand  = (r_cand == CAND_IDX_WIDTH'(NUM_CANDIDATES - 1));
  end

  // Search FSM with accumulator, counters and registered outputs.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state              <= ST_IDLE;
      r_acc                <= {MAX_DATA_WIDTH{1'b0}};
      r_row                <= {ROW_W{1'b0}};
      r_cand               <= {CAND_IDX_WIDTH{1'b0}};
      r_mask               <= {NUM_CANDIDATES{1'b0}};
      out_SAD              <= {MAX_DATA_WIDTH{1'b0}};
      out_SAD_valid_masked <= 1'b0;
      out_cand_idx         <= {CAND_IDX_WIDTH{1'b0}};
      out_busy             <= 1'b0;
      out_search_done      <= 1'b0;
    end else begin
      // Pulses default low; out_SAD and out_cand_idx hold unless overwritten.
      out_SAD_valid_masked <= 1'b0;
      out_search_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_start) begin
            r_mask   <= in_cand_mask;
            r_acc    <= {MAX_DATA_WIDTH{1'b0}};
            r_row    <= {ROW_W{1'b0}};
            r_cand   <= {CAND_IDX_WIDTH{1'b0}};
            out_busy <= 1'b1;
            r_state  <= ST_ACCUM;
          end else begin
            out_busy <= 1'b0;
          end
        end
        ST_ACCUM: begin
          if (in_partial_valid) begin
            if (w_last_row) begin
              // Emit the finished candidate and clear for the next one in the
              // same edge so partials can stream without a bubble.
              out_SAD              <= w_acc_next;
              out_cand_idx         <= r_cand;
              out_SAD_valid_masked <= w_mask_bit;
              r_acc                <= {MAX_DATA_WIDTH{1'b0}};
              r_row                <= {ROW_W{1'b0}};
              r_cand               <= r_cand + CAND_IDX_WIDTH'(1);
              if (w_last_cand) begin
                r_state <= ST_DONE;
              end else begin
                r_state <= ST_ACCUM;
              end
            end else begin
              r_acc <= w_acc_next;
              r_row <= r_row + ROW_W'(1);
            end
          end else begin
            r_state <= ST_ACCUM;
          end
        end
        ST_DONE: begin
          out_search_done <= 1'b1;
          out_busy        <= 1'b0;
          r_state         <= ST_IDLE;
        end
        default: begin
          out_busy <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
